// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with per-byte synchronous write and a registered read.
// The read register returns zero in any cycle that follows a cycle without a read.
import dmem_pkg::*;

module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_BYTES-1:0] wrEn,
    input  logic                  rdEn,
    input  logic [IDX_W-1:0]      addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < WORD_BYTES; b++) begin
            if (wrEn[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= rdEn ? mem[addr] : '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle responder for the CPU data-memory port: FSM, wait counter and decode.
// DMEM_BYTE_ENABLE_EN adds the req_be port and byte-masked stores.
import dmem_pkg::*;

module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_ENABLE_EN
    input  logic [3:0]  req_be,
`endif
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    dmem_state_t           state;
    logic [CNT_W-1:0]      cnt;
    logic                  wrQ;
    logic [31:0]           addrQ;
    logic [31:0]           wdataQ;
    logic [WORD_BYTES-1:0] beQ;
    logic                  readyQ;
    logic                  respValidQ;
    logic                  addrErrQ;

    logic [WORD_BYTES-1:0] beIn;
    logic                  accessNow;
    logic                  accWrite;
    logic [31:0]           accAddr;
    logic [31:0]           accWdata;
    logic [WORD_BYTES-1:0] accBe;
    logic                  accErr;
    logic [WORD_BYTES-1:0] arrWe;
    logic                  arrRe;
    logic [31:0]           arrRdata;

`ifdef DMEM_BYTE_ENABLE_EN
    assign beIn = req_be;
`else
    assign beIn = '1;
`endif

    // With zero wait states the access happens on the acceptance edge, so the
    // live request inputs feed the array instead of the latched copies.
    always_comb begin
        accessNow = 1'b0;
        accWrite  = wrQ;
        accAddr   = addrQ;
        accWdata  = wdataQ;
        accBe     = beQ;
        if (state == IDLE) begin
            accessNow = req_valid && (WAIT_CYCLES == 0);
            accWrite  = req_write;
            accAddr   = req_addr;
            accWdata  = req_wdata;
            accBe     = beIn;
        end else if (state == WAIT) begin
            accessNow = (cnt == '0);
        end
        accErr = (accAddr[1:0] != 2'b00) || ((accAddr >> (IDX_W + 2)) != '0);
        arrWe  = (accessNow && accWrite && !accErr && !reset) ? accBe : '0;
        arrRe  = accessNow && !accWrite && !accErr && !reset;
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .rst  (reset),
        .wrEn (arrWe),
        .rdEn (arrRe),
        .addr (accAddr[2 +: IDX_W]),
        .wdata(accWdata),
        .rdata(arrRdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            wrQ        <= 1'b0;
            addrQ      <= '0;
            wdataQ     <= '0;
            beQ        <= '0;
            readyQ     <= 1'b1;
            respValidQ <= 1'b0;
            addrErrQ   <= 1'b0;
        end else begin
            respValidQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wrQ    <= req_write;
                        addrQ  <= req_addr;
                        wdataQ <= req_wdata;
                        beQ    <= beIn;
                        readyQ <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state      <= RESP;
                            respValidQ <= 1'b1;
                            addrErrQ   <= accErr;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        respValidQ <= 1'b1;
                        addrErrQ   <= accErr;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    readyQ   <= 1'b1;
                    addrErrQ <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    readyQ <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = readyQ;
    assign stall      = ((state == IDLE) && req_valid) || (state == WAIT);
    assign resp_valid = respValidQ;
    assign resp_rdata = arrRdata;
    assign addr_err   = addrErrQ;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance 0 uses WAIT_CYCLES=2, instance 1 uses 0.
module tb_data_mem_responder;

    logic             clk;
    logic [1:0]       rst;
    logic [1:0]       reqValid;
    logic [1:0]       reqWrite;
    logic [1:0][31:0] reqAddr;
    logic [1:0][31:0] reqWdata;
`ifdef DMEM_BYTE_ENABLE_EN
    logic [1:0][3:0]  reqBe;
`endif
    logic [1:0]       reqReady;
    logic [1:0]       stall;
    logic [1:0]       respValid;
    logic [1:0][31:0] respRdata;
    logic [1:0]       addrErr;

    int errors = 0;
    int checks = 0;

    data_mem_responder #(
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(2)
    ) dut0 (
        .clk       (clk),
        .reset     (rst[0]),
        .req_valid (reqValid[0]),
        .req_write (reqWrite[0]),
        .req_addr  (reqAddr[0]),
        .req_wdata (reqWdata[0]),
`ifdef DMEM_BYTE_ENABLE_EN
        .req_be    (reqBe[0]),
`endif
        .req_ready (reqReady[0]),
        .stall     (stall[0]),
        .resp_valid(respValid[0]),
        .resp_rdata(respRdata[0]),
        .addr_err  (addrErr[0])
    );

    data_mem_responder #(
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(0)
    ) dut1 (
        .clk       (clk),
        .reset     (rst[1]),
        .req_valid (reqValid[1]),
        .req_write (reqWrite[1]),
        .req_addr  (reqAddr[1]),
        .req_wdata (reqWdata[1]),
`ifdef DMEM_BYTE_ENABLE_EN
        .req_be    (reqBe[1]),
`endif
        .req_ready (reqReady[1]),
        .stall     (stall[1]),
        .resp_valid(respValid[1]),
        .resp_rdata(respRdata[1]),
        .addr_err  (addrErr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request on instance d, follow it to its response (bounded) and
    // check latency, stall length, error flag and load data.
    task automatic doAccess(input int d, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input int expLat,
                            input logic [31:0] expData, input logic expErr,
                            input string tag);
        int lat = -1;
        int stalls = 0;
        logic [31:0] rd = '0;
        logic er = 1'b0;
        reqValid[d] = 1'b1;
        reqWrite[d] = w;
        reqAddr[d]  = a;
        reqWdata[d] = wd;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (stall[d]) stalls++;
            if (respValid[d]) begin
                lat = c;
                rd  = respRdata[d];
                er  = addrErr[d];
            end
            @(posedge clk);
            #1;
            reqValid[d] = 1'b0;
            reqWrite[d] = ~w;
            reqAddr[d]  = 32'hFFFF_FFF0;
            reqWdata[d] = 32'h0;
            if (lat >= 0) break;
        end
        checkVal({tag, " latency"}, 32'(lat), 32'(expLat));
        checkVal({tag, " stall"}, 32'(stalls), 32'(expLat));
        checkVal({tag, " addr_err"}, {31'd0, er}, {31'd0, expErr});
        if (!w) checkVal({tag, " rdata"}, rd, expData);
    endtask

    initial begin
        int respCnt;
        int accCnt;
        int lastAcc;

        rst      = 2'b11;
        reqValid = '0;
        reqWrite = '0;
        reqAddr  = '0;
        reqWdata = '0;
`ifdef DMEM_BYTE_ENABLE_EN
        reqBe    = '1;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 2'b00;
        #1;
        checkVal("reset ready", {31'd0, reqReady[0]}, 32'd1);
        checkVal("reset stall", {31'd0, stall[0]}, 32'd0);
        checkVal("reset resp_valid", {31'd0, respValid[0]}, 32'd0);
        checkVal("reset rdata", respRdata[0], 32'd0);
        checkVal("reset addr_err", {31'd0, addrErr[0]}, 32'd0);
        checkVal("reset ready w0", {31'd0, reqReady[1]}, 32'd1);

        // Basic store/load with two wait states, then with none.
        doAccess(0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 32'h0, 1'b0, "st10");
        doAccess(0, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, "ld10");
        doAccess(1, 1'b1, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0, "w0 st10");
        doAccess(1, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0, "w0 ld10");

        // Decode boundaries: last word in range, misaligned, out of range.
        doAccess(0, 1'b1, 32'h0, 32'h12345678, 3, 32'h0, 1'b0, "st0");
        doAccess(0, 1'b1, 32'h3FC, 32'hCAFEF00D, 3, 32'h0, 1'b0, "st3fc");
        doAccess(0, 1'b0, 32'h3FC, 32'h0, 3, 32'hCAFEF00D, 1'b0, "ld3fc");
        doAccess(0, 1'b0, 32'h12, 32'h0, 3, 32'h0, 1'b1, "ld12 misaligned");
        doAccess(0, 1'b1, 32'h400, 32'hFFFFFFFF, 3, 32'h0, 1'b1, "st400 range");
        doAccess(0, 1'b0, 32'h400, 32'h0, 3, 32'h0, 1'b1, "ld400 range");
        doAccess(0, 1'b0, 32'h0, 32'h0, 3, 32'h12345678, 1'b0, "ld0 intact");
        doAccess(1, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1, "w0 ld13 misaligned");

        // Reset in the first WAIT cycle abandons the store.
        doAccess(0, 1'b1, 32'h20, 32'h5A5A5A5A, 3, 32'h0, 1'b0, "st20");
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b1;
        reqAddr[0]  = 32'h20;
        reqWdata[0] = 32'h11111111;
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        checkVal("abort stall in wait", {31'd0, stall[0]}, 32'd1);
        rst[0] = 1'b1;
        #1;
        checkVal("abort ready", {31'd0, reqReady[0]}, 32'd1);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        respCnt = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (respValid[0]) respCnt++;
            @(posedge clk);
            #1;
        end
        checkVal("abort no resp", 32'(respCnt), 32'd0);
        doAccess(0, 1'b0, 32'h20, 32'h0, 3, 32'h5A5A5A5A, 1'b0, "ld20 after abort");

`ifdef DMEM_BYTE_ENABLE_EN
        reqBe[0] = 4'b1111;
        doAccess(0, 1'b1, 32'h30, 32'hAABBCCDD, 3, 32'h0, 1'b0, "be st full");
        reqBe[0] = 4'b0001;
        doAccess(0, 1'b1, 32'h30, 32'h00000011, 3, 32'h0, 1'b0, "be st byte0");
        reqBe[0] = 4'b0000;
        doAccess(0, 1'b1, 32'h30, 32'hFFFFFFFF, 3, 32'h0, 1'b0, "be st none");
        reqBe[0] = 4'b0010;
        doAccess(0, 1'b0, 32'h30, 32'h0, 3, 32'hAABBCC11, 1'b0, "be ld");
        reqBe[0] = 4'b1111;
`endif

        // Continuous req_valid: accepts only in IDLE, every WAIT_CYCLES+2 cycles.
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b0;
        reqAddr[0]  = 32'h10;
        accCnt  = 0;
        respCnt = 0;
        lastAcc = -1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (reqReady[0] && reqValid[0]) begin
                if (lastAcc >= 0) checkVal("stream spacing", 32'(c - lastAcc), 32'd4);
                lastAcc = c;
                accCnt++;
            end
            if (respValid[0]) begin
                respCnt++;
                checkVal("stream rdata", respRdata[0], 32'hDEADBEEF);
            end
            @(posedge clk);
            #1;
        end
        reqValid[0] = 1'b0;
        checkVal("stream accepts", 32'(accCnt), 32'd4);
        checkVal("stream responses", 32'(respCnt), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
